// File: rtl/count_sequencer.sv
// Run-control sequencer: button debounce, up/down/pause FSM, tick prescaler.
// Optional feature macro: AUTO_REVERSE_EN (bounce the count at 0 / all-ones).
module count_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 100_000_000,
    parameter int COUNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_dir,
    input  logic               btn_pause,
    input  logic [COUNT_W-1:0] count_in,
    output logic               tick,
    output logic               UP_DOWN,
    output logic               pause,
    output logic [1:0]         state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_UP         = 2'b00,
        S_DOWN       = 2'b01,
        S_PAUSE_UP   = 2'b10,
        S_PAUSE_DOWN = 2'b11
    } state_e;

    // Bit 0 is the direction button, bit 1 the pause button.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            lvl_q;
    logic [1:0]            lvl_d;
    logic [1:0]            hist_q;
    logic [1:0]            press;
    logic [1:0][DB_W-1:0]  db_cnt_q;
    logic [1:0][DB_W-1:0]  db_cnt_d;

    state_e                state_q;
    state_e                state_d;
    logic                  up_down_q;
    logic                  up_down_d;
    logic                  pause_q;
    logic                  pause_d;
    logic                  auto_rev;
    logic                  dir_toggle;

    logic [PS_W-1:0]       presc_q;
    logic [PS_W-1:0]       presc_d;
    logic                  tick_q;
    logic                  tick_d;

    assign btn_raw = {btn_pause, btn_dir};
    assign press   = lvl_q & ~hist_q;

    // Debounce: count consecutive samples that disagree with the accepted level.
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Synchronizers, debounce counters, accepted levels and edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            hist_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            hist_q   <= lvl_q;
            db_cnt_q <= db_cnt_d;
        end
    end

`ifdef AUTO_REVERSE_EN
    // Running states flip direction when the count reaches its end stop.
    assign auto_rev = ~state_q[1] &
                      ((~state_q[0] & (count_in == {COUNT_W{1'b1}})) |
                       ( state_q[0] & (count_in == '0)));
`else
    logic unused_count_in;
    assign unused_count_in = ^count_in;
    assign auto_rev = 1'b0;
`endif

    // A press and an auto-reverse together still flip direction only once.
    assign dir_toggle = press[0] | auto_rev;

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_UP;
            up_down_q <= 1'b1;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            up_down_q <= up_down_d;
            pause_q   <= pause_d;
        end
    end

    // FSM next state: each press toggles its own state bit.
    always_comb begin
        state_d = state_e'({state_q[1] ^ press[1], state_q[0] ^ dir_toggle});
    end

    // FSM outputs, derived from the next state so they register with it.
    always_comb begin
        up_down_d = ~state_d[0];
        pause_d   = state_d[1];
    end

    // Prescaler next state: hold while paused, wrap and tick at TICK_DIV-1.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (!state_q[1]) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    // Prescaler and registered tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign UP_DOWN = up_down_q;
    assign pause   = pause_q;
    assign state   = state_q;

endmodule
